// File: rtl/led_ctrl_pkg.sv
// Shared mode encoding and press-FSM state type for the LED mode controller.
package led_ctrl_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_OFF  = 2'd0;
    localparam logic [MODE_W-1:0] MODE_ON   = 2'd1;
    localparam logic [MODE_W-1:0] MODE_SLOW = 2'd2;
    localparam logic [MODE_W-1:0] MODE_FAST = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_LONG_HELD = 2'd2
    } press_state_t;

    // Short-press mode sequence: OFF -> ON -> SLOW -> FAST -> OFF
    function automatic logic [MODE_W-1:0] mode_next(input logic [MODE_W-1:0] mode);
        case (mode)
            MODE_OFF:  return MODE_ON;
            MODE_ON:   return MODE_SLOW;
            MODE_SLOW: return MODE_FAST;
            default:   return MODE_OFF;
        endcase
    endfunction

endpackage

// File: rtl/led_mode_ctrl_if.sv
// Button-in / LED-and-mode-out signal bundle for led_mode_ctrl.
interface led_mode_ctrl_if;

    logic       i_Btn_C;
    logic       o_LED_1;
    logic [1:0] o_Mode;
    logic       o_Long_Pulse;

    // Board / stimulus side: drives the button, observes the LED state
    modport master (
        output i_Btn_C,
        input  o_LED_1,
        input  o_Mode,
        input  o_Long_Pulse
    );

    // Controller side
    modport slave (
        input  i_Btn_C,
        output o_LED_1,
        output o_Mode,
        output o_Long_Pulse
    );

endinterface

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus counter debounce for a raw push-button.
// Emits the accepted level and one-cycle rise/fall strobes on each flip.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;
    logic [CNT_W-1:0] cnt_q;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                level_q <= sync2_q;
                rise_q  <= sync2_q;
                fall_q  <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// Single-button LED mode controller: short press cycles OFF/ON/SLOW/FAST,
// long press forces OFF. Press FSM, mode register and blink generator live here.
module led_mode_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 250000,
    parameter int unsigned LONG_PRESS_CYCLES = 25000000,
    parameter int unsigned SLOW_HALF         = 12500000,
    parameter int unsigned FAST_HALF         = 3125000
) (
    input  logic           i_Clk,
    input  logic           i_Rst_n,
    led_mode_ctrl_if.slave bus
);

    localparam int unsigned HOLD_W    = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
    localparam int unsigned BLINK_MAX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
    localparam int unsigned BLINK_W   = (BLINK_MAX > 1) ? $clog2(BLINK_MAX) : 1;

    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [BLINK_W-1:0] SLOW_LAST = BLINK_W'(SLOW_HALF - 1);
    localparam logic [BLINK_W-1:0] FAST_LAST = BLINK_W'(FAST_HALF - 1);

    logic btn_level;
    logic btn_rise;
    logic btn_fall;

    press_state_t        state_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [MODE_W-1:0]   mode_q;
    logic [MODE_W-1:0]   mode_d;
    logic                long_pulse_q;
    logic                led_q;
    logic [BLINK_W-1:0]  blink_q;
    logic                short_c;
    logic                long_c;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (i_Clk),
        .rst_n   (i_Rst_n),
        .btn_i   (bus.i_Btn_C),
        .level_o (btn_level),
        .rise_o  (btn_rise),
        .fall_o  (btn_fall)
    );

    // Classify the press this cycle; a release always beats the long-press terminal count
    always_comb begin
        short_c = 1'b0;
        long_c  = 1'b0;
        mode_d  = mode_q;
        if (state_q == ST_PRESSED) begin
            if (btn_fall) begin
                short_c = 1'b1;
            end else if (btn_level && (hold_q == HOLD_LAST)) begin
                long_c = 1'b1;
            end
        end
        if (short_c) begin
            mode_d = mode_next(mode_q);
        end else if (long_c) begin
            mode_d = MODE_OFF;
        end
    end

    // Press FSM, hold counter, mode register and long-press strobe
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            mode_q       <= MODE_OFF;
            long_pulse_q <= 1'b0;
        end else begin
            long_pulse_q <= long_c;
            mode_q       <= mode_d;
            case (state_q)
                ST_IDLE: begin
                    if (btn_rise) begin
                        state_q <= ST_PRESSED;
                        hold_q  <= '0;
                    end
                end
                ST_PRESSED: begin
                    if (short_c) begin
                        state_q <= ST_IDLE;
                        hold_q  <= '0;
                    end else if (long_c) begin
                        state_q <= ST_LONG_HELD;
                        hold_q  <= '0;
                    end else if (hold_q != HOLD_LAST) begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                ST_LONG_HELD: begin
                    if (btn_fall) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    hold_q  <= '0;
                end
            endcase
        end
    end

    // LED drive; a mode change restarts the blink phase with the LED lit
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            led_q   <= 1'b0;
            blink_q <= '0;
        end else if (short_c || long_c) begin
            led_q   <= (mode_d != MODE_OFF);
            blink_q <= '0;
        end else begin
            case (mode_q)
                MODE_OFF: begin
                    led_q   <= 1'b0;
                    blink_q <= '0;
                end
                MODE_ON: begin
                    led_q   <= 1'b1;
                    blink_q <= '0;
                end
                MODE_SLOW: begin
                    if (blink_q == SLOW_LAST) begin
                        led_q   <= ~led_q;
                        blink_q <= '0;
                    end else begin
                        blink_q <= blink_q + BLINK_W'(1);
                    end
                end
                default: begin
                    if (blink_q == FAST_LAST) begin
                        led_q   <= ~led_q;
                        blink_q <= '0;
                    end else begin
                        blink_q <= blink_q + BLINK_W'(1);
                    end
                end
            endcase
        end
    end

    assign bus.o_LED_1      = led_q;
    assign bus.o_Mode       = mode_q;
    assign bus.o_Long_Pulse = long_pulse_q;

endmodule

// File: doc/led_mode_ctrl.md
LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000: consecutive cycles a raw button level must persist before it is accepted.
REQ-002 Parameter LONG_PRESS_CYCLES, default 25000000: held cycles after which a press is classified as long.
REQ-003 Parameter SLOW_HALF, default 12500000: LED half-period in cycles in SLOW mode.
REQ-004 Parameter FAST_HALF, default 3125000: LED half-period in cycles in FAST mode.
REQ-005 i_Clk  input  1  sole clock; all state rising-edge triggered.
REQ-006 i_Rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 i_Btn_C  input  1  raw push-button, asynchronous, active-high, bouncy.
REQ-008 o_LED_1  output  1  LED drive, registered.
REQ-009 o_Mode  output  2  current mode: 0 OFF, 1 ON, 2 SLOW, 3 FAST; registered.
REQ-010 o_Long_Pulse  output  1  one-cycle strobe when a long press is recognised.

Function
REQ-011 i_Btn_C SHALL pass through a 2-flop synchroniser before any other use.
REQ-012 Debounce: the counter SHALL increment while the synced level differs from the accepted level and SHALL clear when they match; at count DEBOUNCE_CYCLES-1 the accepted level SHALL flip and the counter SHALL clear.
REQ-013 Press FSM states SHALL be IDLE, PRESSED and LONG_HELD.
REQ-014 IDLE -> PRESSED on an accepted 0->1 transition; the hold counter SHALL clear.
REQ-015 PRESSED: the hold counter increments each cycle; at LONG_PRESS_CYCLES-1 -> LONG_HELD, o_Mode <= OFF, o_Long_Pulse = 1 for exactly that one cycle.
REQ-016 PRESSED with an accepted 1->0 transition (short press) -> IDLE, and o_Mode SHALL advance OFF->ON->SLOW->FAST->OFF (wrap) on the same edge.
REQ-017 LONG_HELD with an accepted 1->0 transition -> IDLE with no mode change.
REQ-018 If the hold-counter terminal count and an accepted release coincide, release SHALL win: short press, no long pulse.
REQ-019 o_LED_1: OFF = 0; ON = 1; SLOW/FAST toggles each SLOW_HALF/FAST_HALF cycles.
REQ-020 On every o_Mode change, the blink counter SHALL clear, and o_LED_1 SHALL be 1 in the first cycle of a SLOW or FAST mode.
REQ-021 Latency from a clean raw edge to the accepted edge SHALL be 2 + DEBOUNCE_CYCLES cycles; o_Mode and o_LED_1 SHALL update one cycle after the accepted edge.
REQ-022 Counter widths SHALL be $clog2 of the corresponding parameter; counters SHALL never wrap silently.

Reset
REQ-023 While i_Rst_n = 0: o_LED_1 = 0, o_Mode = OFF, o_Long_Pulse = 0, FSM = IDLE, synchroniser and accepted level = 0, all counters = 0.
REQ-024 Reset mid-press SHALL abort the press with no mode advance; a button held across reset release SHALL debounce and count as a new press.

Structure
REQ-025 Shared package led_ctrl_pkg SHALL hold the mode encoding constants (MODE_OFF..MODE_FAST) and the press-FSM state type.
REQ-026 Synchroniser plus debounce SHALL be one sub-module, button_debounce, which outputs the accepted level and one-cycle rise/fall strobes.
REQ-027 The FSM, mode register and blink generator SHALL live in led_mode_ctrl.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, SLOW_HALF=8, FAST_HALF=2)
REQ-028 Clean press of 10 cycles, then release -> o_Mode 0->1 exactly 7 cycles after the release edge; o_LED_1 = 1; o_Long_Pulse never set.
REQ-029 Four short presses -> o_Mode = 1, 2, 3, 0; in mode 2, o_LED_1 period = 16 cycles; in mode 3, period = 4 cycles; first cycle of each blink mode = 1.
REQ-030 Bounce: 1-2 cycle glitches on i_Btn_C for 30 cycles, never stable for 4 cycles -> no mode change.
REQ-031 In mode 3, hold 40 cycles -> o_Long_Pulse single cycle, o_Mode = 0, o_LED_1 = 0; after release, o_Mode stays 0.
REQ-032 Release timed so the accepted fall coincides with hold count 19 -> o_Mode advances and no o_Long_Pulse.
REQ-033 Assert i_Rst_n = 0 mid-press in mode 2 -> all outputs 0 immediately; button held through reset release -> after 2 + 4 cycles, a press is accepted and a later release gives o_Mode = 1.
